// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : clock_set_ctrl_if
//  Purpose   : Button, counter-time and control/display signals between the
//              surrounding logic (master) and the clock set controller (slave).
//  Revision  : 1.0  initial release
// ============================================================================
interface clock_set_ctrl_if;
    // debounced button levels and current counter time
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic       cur_pm;

    // controller outputs
    logic       ena_tick;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic       load_pm;
    logic [7:0] disp_hh;
    logic [7:0] disp_mm;
    logic       disp_pm;
    logic [1:0] edit_sel;
    logic       blink_on;

    // environment side: drives buttons and the counter time
    modport master (
        output btn_mode, btn_inc, cur_hh, cur_mm, cur_pm,
        input  ena_tick, load, load_hh, load_mm, load_pm,
               disp_hh, disp_mm, disp_pm, edit_sel, blink_on
    );

    // controller side
    modport slave (
        input  btn_mode, btn_inc, cur_hh, cur_mm, cur_pm,
        output ena_tick, load, load_hh, load_mm, load_pm,
               disp_hh, disp_mm, disp_pm, edit_sel, blink_on
    );
endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl
//  Purpose  : Sequencer for a 12-hour BCD clock. Generates the 1 Hz count
//             enable and runs the RUN -> SET_HH -> SET_MM -> RUN time-set
//             mode, editing a shadow copy of the time and loading it into
//             the counter on leaving SET_MM.
//  Revision : 1.0  initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input wire               clk,
    input wire               reset_n,
    clock_set_ctrl_if.slave  bus
);

    localparam int c_TW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int c_BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_TW-1:0] c_tick_last  = c_TW'(TICK_DIV - 1);
    localparam logic [c_BW-1:0] c_blink_last = c_BW'(BLINK_DIV - 1);

    // state encoding doubles as the edit_sel output value
    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_SET_HH = 2'b01,
        S_SET_MM = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              btn_mode_q, btn_inc_q;
    logic [7:0]        hh_q, hh_d;
    logic [7:0]        mm_q, mm_d;
    logic              pm_q, pm_d;
    logic              load_q, load_d;
    logic              ena_q, ena_d;
    logic [c_TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [c_BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic [7:0]        disp_hh_q, disp_hh_d;
    logic [7:0]        disp_mm_q, disp_mm_d;
    logic              disp_pm_q, disp_pm_d;

    logic              w_mode_edge;
    logic              w_inc_edge;
    logic              w_in_run;
    logic [8:0]        w_hh_inc;
    logic [7:0]        w_mm_inc;

    // 12-hour BCD increment; 11 -> 12 flips pm to match the counter's rollover
    function automatic logic [8:0] inc_hours(input logic [7:0] hh, input logic pm);
        if (hh == 8'h12)
            return {pm, 8'h01};
        else if (hh == 8'h11)
            return {~pm, 8'h12};
        else if (hh[3:0] == 4'd9)
            return {pm, hh[7:4] + 4'd1, 4'd0};
        else
            return {pm, hh[7:4], hh[3:0] + 4'd1};
    endfunction

    // BCD minutes increment, 59 wraps to 00 without touching hours
    function automatic logic [7:0] inc_minutes(input logic [7:0] mm);
        if (mm[3:0] == 4'd9) begin
            if (mm[7:4] == 4'd5)
                return 8'h00;
            else
                return {mm[7:4] + 4'd1, 4'd0};
        end else begin
            return {mm[7:4], mm[3:0] + 4'd1};
        end
    endfunction

    assign w_mode_edge = bus.btn_mode & ~btn_mode_q;
    assign w_inc_edge  = bus.btn_inc  & ~btn_inc_q;
    assign w_in_run    = (state_q == S_RUN);
    assign w_hh_inc    = inc_hours(hh_q, pm_q);
    assign w_mm_inc    = inc_minutes(mm_q);

    // next-state: mode FSM, shadow edits, prescaler, blink and display select
    always_comb begin
        state_d     = state_q;
        hh_d        = hh_q;
        mm_d        = mm_q;
        pm_d        = pm_q;
        load_d      = 1'b0;
        ena_d       = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        disp_hh_d   = disp_hh_q;
        disp_mm_d   = disp_mm_q;
        disp_pm_d   = disp_pm_q;

        // a mode edge always wins over a simultaneous inc edge
        case (state_q)
            S_RUN: begin
                if (w_mode_edge) begin
                    state_d = S_SET_HH;
                    hh_d    = bus.cur_hh;
                    mm_d    = bus.cur_mm;
                    pm_d    = bus.cur_pm;
                end
            end
            S_SET_HH: begin
                if (w_mode_edge)
                    state_d = S_SET_MM;
                else if (w_inc_edge)
                    {pm_d, hh_d} = w_hh_inc;
            end
            S_SET_MM: begin
                if (w_mode_edge) begin
                    state_d = S_RUN;
                    load_d  = 1'b1;
                end else if (w_inc_edge) begin
                    mm_d = w_mm_inc;
                end
            end
            default: state_d = S_RUN;
        endcase

        // prescaler runs only while staying in RUN, so it restarts from 0
        // after a load and the first tick lands TICK_DIV cycles later
        if (!w_in_run || w_mode_edge) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q == c_tick_last) begin
            tick_cnt_d = '0;
            ena_d      = 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        // blink restarts visible on every mode step and every edit
        if (state_d == S_RUN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (w_mode_edge || w_inc_edge) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        if (state_d == S_RUN) begin
            disp_hh_d = bus.cur_hh;
            disp_mm_d = bus.cur_mm;
            disp_pm_d = bus.cur_pm;
        end else begin
            disp_hh_d = hh_d;
            disp_mm_d = mm_d;
            disp_pm_d = pm_d;
        end
    end

    // state and output registers; reset discards any pending edit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            btn_mode_q  <= 1'b0;
            btn_inc_q   <= 1'b0;
            hh_q        <= 8'h12;
            mm_q        <= 8'h00;
            pm_q        <= 1'b0;
            load_q      <= 1'b0;
            ena_q       <= 1'b0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            disp_hh_q   <= bus.cur_hh;
            disp_mm_q   <= bus.cur_mm;
            disp_pm_q   <= bus.cur_pm;
        end else begin
            state_q     <= state_d;
            btn_mode_q  <= bus.btn_mode;
            btn_inc_q   <= bus.btn_inc;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            pm_q        <= pm_d;
            load_q      <= load_d;
            ena_q       <= ena_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            disp_hh_q   <= disp_hh_d;
            disp_mm_q   <= disp_mm_d;
            disp_pm_q   <= disp_pm_d;
        end
    end

    assign bus.ena_tick = ena_q;
    assign bus.load     = load_q;
    assign bus.load_hh  = hh_q;
    assign bus.load_mm  = mm_q;
    assign bus.load_pm  = pm_q;
    assign bus.disp_hh  = disp_hh_q;
    assign bus.disp_mm  = disp_mm_q;
    assign bus.disp_pm  = disp_pm_q;
    assign bus.edit_sel = state_q;
    assign bus.blink_on = blink_q;

endmodule
`default_nettype wire
